gate_stim_checker: RTL and testbench
====================================

# gate_stim_checker

Self-checking stimulus sequencer for the two-input gate blocks. It drives the gate's `a`/`b` inputs through the full truth table (00, 01, 10, 11), holds each vector for a programmable number of cycles, and samples the gate's `y` output. It compares `y` against the expected function, then reports the mismatch count and the first failing vector. The block sits directly upstream (stimulus) and downstream (checker) of the gate under test, so a bench only needs to wire it up and pulse `start`.

## Interface
Parameters:
- `HOLD_CYCLES`, default 20: cycles each vector is driven; legal range 1..255.
- `NUM_PASSES`, default 1: full truth-table sweeps per run; legal range 1..255.
- `GATE_OP`, default 0: expected function. 0=AND, 1=OR, 2=XOR, 3=NAND.

Ports:
- `clk`, input, 1: single clock, all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `start`, input, 1: begin a run; honoured only in IDLE or DONE.
- `a_out`, output, 1: drives the gate input `a`; equals vector bit 1.
- `b_out`, output, 1: drives the gate input `b`; equals vector bit 0.
- `y_in`, input, 1: gate output under test.
- `busy`, output, 1: high while in DRIVE.
- `done`, output, 1: level; high in DONE.
- `pass`, output, 1: `done && err_count==0`.
- `mismatch`, output, 1: one-cycle pulse after a failing sample.
- `err_count`, output, 8: mismatches this run; saturates at 255.
- `first_fail`, output, 2: vector of the first mismatch this run; 0 if none.

## Operation
- Internal state:
  - `vec` (2 bits).
  - `hold_cnt` (8 bits).
  - `pass_cnt` (8 bits).
  - FSM with states IDLE, DRIVE, DONE.
  - `fail_seen` flag.
- `a_out`/`b_out` are decoded combinationally from the `vec` register; there is no extra output latency.
- Expected value is `f(vec[1], vec[0])` per `GATE_OP`.
- IDLE -> DRIVE when `start`=1:
  - clear `vec`, `hold_cnt`, `pass_cnt`, `err_count`, `first_fail` and `fail_seen`.
- DRIVE, each edge:
  - if `hold_cnt == HOLD_CYCLES-1`, sample `y_in` against the expected value.
    - On mismatch: `err_count` += 1 (saturating) and `mismatch`<=1.
    - On mismatch with `fail_seen`=0: `first_fail`<=`vec` and `fail_seen`<=1.
  - on a sample edge, advance:
    - if `vec==3` and `pass_cnt==NUM_PASSES-1`: go to DONE.
    - otherwise: `vec` += 1 (wrapping 3->0, with `pass_cnt` += 1 on the wrap) and `hold_cnt`<=0.
  - otherwise `hold_cnt` += 1.
- DONE:
  - `a_out`/`b_out` hold the last vector (11).
  - `start`=1 restarts exactly as from IDLE, clearing all results.
- `start` in DRIVE is ignored; it does not restart or extend the run.
- `rst` overrides everything, including mid-run: next state IDLE, all counters cleared.

## Timing
- Reset values:
  - `a_out`=0, `b_out`=0.
  - `busy`=0, `done`=0, `pass`=0, `mismatch`=0.
  - `err_count`=0, `first_fail`=0.
- Edge E0 (`start` sampled high in IDLE/DONE): `busy`=1 and vector 00 is visible after E0.
- Each vector is driven for exactly `HOLD_CYCLES` cycles.
- `y_in` is sampled on the final edge of each hold window.
  - With `HOLD_CYCLES`=1 the gate is assumed to be purely combinational: same-cycle sampling.
- DONE is entered at edge E0 + 4·NUM_PASSES·HOLD_CYCLES.
  - `busy` falls and `done`/`pass` rise together at that edge.
- `mismatch` is high for the one cycle following the failing sample edge.
  - This includes the final sample; `mismatch` may coincide with `done` rising.
- `err_count` updates on the sample edge. It holds at 255 once saturated, and `mismatch` still pulses.
- `first_fail` is written only once per run.

## Test plan
- AND gate correct, `HOLD_CYCLES`=4, `NUM_PASSES`=1: pulse `start`.
  - `a_out`/`b_out` step 00,01,10,11, each for 4 cycles.
  - `done` rises 16 cycles after E0; `err_count`=0, `pass`=1, `mismatch` never high.
- `y_in` stuck at 0, `GATE_OP`=0, `HOLD_CYCLES`=2 -> `err_count`=1, `first_fail`=3, `pass`=0, one `mismatch` pulse coinciding with `done` rising.
- `y_in` stuck at 1, `GATE_OP`=0 -> `err_count`=3, `first_fail`=0, three `mismatch` pulses.
- `y_in` = NOT(a&b), `NUM_PASSES`=100, `HOLD_CYCLES`=1 -> 400 failing samples, `err_count`=255 (saturated), `done` 400 cycles after E0.
- `start` re-asserted mid-run -> no effect on the sequence or on `done` timing.
  - `start` asserted again in DONE -> results cleared and a full run repeats.
- `rst` asserted during vector 10 with errors accumulated.
  - Next cycle: all outputs at reset values and state IDLE.
  - A subsequent `start` gives a clean full-length run.

Source files
------------

// File: rtl/gate_stim_checker.sv
// Truth-table stimulus sequencer and checker for a two-input gate under test.
// Drives a/b through 00..11, samples y at the end of each hold window, tallies mismatches.
module gate_stim_checker #(
  parameter int unsigned HOLD_CYCLES = 20,
  parameter int unsigned NUM_PASSES  = 1,
  parameter int unsigned GATE_OP     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic       y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       mismatch,
  output logic [7:0] err_count,
  output logic [1:0] first_fail
);

  typedef enum logic [1:0] {StIdle, StDrive, StDone} state_e;

  localparam logic [7:0] HoldLast = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] PassLast = 8'(NUM_PASSES - 1);

  state_e     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [7:0] pass_cnt_q, pass_cnt_d;
  logic [7:0] err_q, err_d;
  logic [1:0] first_fail_q, first_fail_d;
  logic       fail_seen_q, fail_seen_d;
  logic       mismatch_q, mismatch_d;
  logic       expected;

  always_comb begin
    case (GATE_OP)
      1:       expected = vec_q[1] | vec_q[0];
      2:       expected = vec_q[1] ^ vec_q[0];
      3:       expected = ~(vec_q[1] & vec_q[0]);
      default: expected = vec_q[1] & vec_q[0];
    endcase
  end

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    hold_cnt_d   = hold_cnt_q;
    pass_cnt_d   = pass_cnt_q;
    err_d        = err_q;
    first_fail_d = first_fail_q;
    fail_seen_d  = fail_seen_q;
    mismatch_d   = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d      = StDrive;
          vec_d        = 2'd0;
          hold_cnt_d   = 8'd0;
          pass_cnt_d   = 8'd0;
          err_d        = 8'd0;
          first_fail_d = 2'd0;
          fail_seen_d  = 1'b0;
        end
      end
      StDrive: begin
        if (hold_cnt_q == HoldLast) begin
          if (y_in != expected) begin
            mismatch_d = 1'b1;
            if (err_q != 8'hff) err_d = err_q + 8'd1;
            if (!fail_seen_q) begin
              first_fail_d = vec_q;
              fail_seen_d  = 1'b1;
            end
          end
          if (vec_q == 2'd3 && pass_cnt_q == PassLast) begin
            state_d = StDone;
          end else begin
            vec_d      = vec_q + 2'd1;
            hold_cnt_d = 8'd0;
            if (vec_q == 2'd3) pass_cnt_d = pass_cnt_q + 8'd1;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      vec_q        <= 2'd0;
      hold_cnt_q   <= 8'd0;
      pass_cnt_q   <= 8'd0;
      err_q        <= 8'd0;
      first_fail_q <= 2'd0;
      fail_seen_q  <= 1'b0;
      mismatch_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      hold_cnt_q   <= hold_cnt_d;
      pass_cnt_q   <= pass_cnt_d;
      err_q        <= err_d;
      first_fail_q <= first_fail_d;
      fail_seen_q  <= fail_seen_d;
      mismatch_q   <= mismatch_d;
    end
  end

  assign a_out      = vec_q[1];
  assign b_out      = vec_q[0];
  assign busy       = (state_q == StDrive);
  assign done       = (state_q == StDone);
  assign pass       = done && (err_q == 8'd0);
  assign mismatch   = mismatch_q;
  assign err_count  = err_q;
  assign first_fail = first_fail_q;

endmodule

// File: tb/tb_gate_stim_checker.sv
// Directed bench for gate_stim_checker: several parameterisations, each fed a good or faulty gate.
module tb_gate_stim_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // u_and: AND, hold 4, 1 pass; gate behaviour selected by mode_and
  int mode_and = 0;
  logic st_and = 1'b0, a_and, b_and, y_and, busy_and, done_and, pass_and, mm_and;
  logic [7:0] err_and;
  logic [1:0] ff_and;
  assign y_and = (mode_and == 0) ? (a_and & b_and) : (mode_and == 1) ? 1'b0 : 1'b1;

  // u_h2: AND, hold 2, y stuck at 0
  logic st_h2 = 1'b0, a_h2, b_h2, busy_h2, done_h2, pass_h2, mm_h2;
  logic [7:0] err_h2;
  logic [1:0] ff_h2;

  // u_sat: AND, hold 1, 100 passes, y = NAND
  logic st_sat = 1'b0, a_sat, b_sat, y_sat, busy_sat, done_sat, pass_sat, mm_sat;
  logic [7:0] err_sat;
  logic [1:0] ff_sat;
  assign y_sat = ~(a_sat & b_sat);

  // u_xor: XOR, hold 3, fed an OR gate
  logic st_xor = 1'b0, a_xor, b_xor, y_xor, busy_xor, done_xor, pass_xor, mm_xor;
  logic [7:0] err_xor;
  logic [1:0] ff_xor;
  assign y_xor = a_xor | b_xor;

  // u_nand: NAND, hold 1, 2 passes, correct gate
  logic st_nand = 1'b0, a_nand, b_nand, y_nand, busy_nand, done_nand, pass_nand, mm_nand;
  logic [7:0] err_nand;
  logic [1:0] ff_nand;
  assign y_nand = ~(a_nand & b_nand);

  gate_stim_checker #(.HOLD_CYCLES(4), .NUM_PASSES(1), .GATE_OP(0)) u_and (
    .clk(clk), .rst(rst), .start(st_and), .a_out(a_and), .b_out(b_and), .y_in(y_and),
    .busy(busy_and), .done(done_and), .pass(pass_and), .mismatch(mm_and),
    .err_count(err_and), .first_fail(ff_and));

  gate_stim_checker #(.HOLD_CYCLES(2), .NUM_PASSES(1), .GATE_OP(0)) u_h2 (
    .clk(clk), .rst(rst), .start(st_h2), .a_out(a_h2), .b_out(b_h2), .y_in(1'b0),
    .busy(busy_h2), .done(done_h2), .pass(pass_h2), .mismatch(mm_h2),
    .err_count(err_h2), .first_fail(ff_h2));

  gate_stim_checker #(.HOLD_CYCLES(1), .NUM_PASSES(100), .GATE_OP(0)) u_sat (
    .clk(clk), .rst(rst), .start(st_sat), .a_out(a_sat), .b_out(b_sat), .y_in(y_sat),
    .busy(busy_sat), .done(done_sat), .pass(pass_sat), .mismatch(mm_sat),
    .err_count(err_sat), .first_fail(ff_sat));

  gate_stim_checker #(.HOLD_CYCLES(3), .NUM_PASSES(1), .GATE_OP(2)) u_xor (
    .clk(clk), .rst(rst), .start(st_xor), .a_out(a_xor), .b_out(b_xor), .y_in(y_xor),
    .busy(busy_xor), .done(done_xor), .pass(pass_xor), .mismatch(mm_xor),
    .err_count(err_xor), .first_fail(ff_xor));

  gate_stim_checker #(.HOLD_CYCLES(1), .NUM_PASSES(2), .GATE_OP(3)) u_nand (
    .clk(clk), .rst(rst), .start(st_nand), .a_out(a_nand), .b_out(b_nand), .y_in(y_nand),
    .busy(busy_nand), .done(done_nand), .pass(pass_nand), .mismatch(mm_nand),
    .err_count(err_nand), .first_fail(ff_nand));

  // Mismatch pulse tallies, sampled mid-cycle
  int n_mm_and = 0, n_mm_h2 = 0, n_mm_sat = 0, n_mm_xor = 0, n_mm_nand = 0;
  always @(negedge clk) begin
    if (mm_and)  n_mm_and++;
    if (mm_h2)   n_mm_h2++;
    if (mm_sat)  n_mm_sat++;
    if (mm_xor)  n_mm_xor++;
    if (mm_nand) n_mm_nand++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic done_of(input int which);
    case (which)
      0:       return done_and;
      1:       return done_h2;
      2:       return done_sat;
      3:       return done_xor;
      default: return done_nand;
    endcase
  endfunction

  // Call right after the start edge; returns edges from E0 until done is seen.
  task automatic wait_done(input int which, output int cycles);
    cycles = 0;
    while (!done_of(which) && cycles < 1000) begin
      tick();
      cycles++;
    end
  endtask

  task automatic all_reset_vals(input string pfx);
    check({pfx, "_a"}, a_and, 0);
    check({pfx, "_b"}, b_and, 0);
    check({pfx, "_busy"}, busy_and, 0);
    check({pfx, "_done"}, done_and, 0);
    check({pfx, "_pass"}, pass_and, 0);
    check({pfx, "_mm"}, mm_and, 0);
    check({pfx, "_err"}, err_and, 0);
    check({pfx, "_ff"}, ff_and, 0);
  endtask

  initial begin
    int cyc;
    int base;

    tick();
    tick();
    all_reset_vals("reset");
    rst = 1'b0;
    tick();

    // Run A: AND with y stuck at 1 -> fails at 00, 01, 10
    mode_and = 2;
    base = n_mm_and;
    st_and = 1'b1;
    tick();
    st_and = 1'b0;
    check("a_busy_e0", busy_and, 1);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("a_vec%0d", k), {a_and, b_and}, k / 4);
      check($sformatf("a_done%0d", k), done_and, 0);
      tick();
    end
    check("a_done", done_and, 1);
    check("a_busy", busy_and, 0);
    check("a_pass", pass_and, 0);
    check("a_err", err_and, 3);
    check("a_ff", ff_and, 0);
    tick();
    check("a_hold11", {a_and, b_and}, 3);
    check("a_mm_pulses", n_mm_and - base, 3);

    // Run B: restart from DONE with a correct gate; start pulsed mid-run is ignored
    mode_and = 0;
    base = n_mm_and;
    st_and = 1'b1;
    tick();
    st_and = 1'b0;
    check("b_err_cleared", err_and, 0);
    check("b_done_cleared", done_and, 0);
    check("b_busy", busy_and, 1);
    for (int k = 0; k < 16; k++) begin
      if (k == 5) st_and = 1'b1;
      if (k == 8) st_and = 1'b0;
      check($sformatf("b_vec%0d", k), {a_and, b_and}, k / 4);
      check($sformatf("b_done%0d", k), done_and, 0);
      tick();
    end
    check("b_done", done_and, 1);
    check("b_pass", pass_and, 1);
    check("b_err", err_and, 0);
    tick();
    check("b_mm_pulses", n_mm_and - base, 0);

    // Run C: reset during vector 10 with two errors accumulated, then a clean run
    mode_and = 2;
    st_and = 1'b1;
    tick();
    st_and = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    check("c_vec10", {a_and, b_and}, 2);
    check("c_err_mid", err_and, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    all_reset_vals("c_rst");
    tick();
    tick();
    tick();
    check("c_idle_busy", busy_and, 0);
    check("c_idle_done", done_and, 0);
    check("c_idle_vec", {a_and, b_and}, 0);
    mode_and = 0;
    st_and = 1'b1;
    tick();
    st_and = 1'b0;
    wait_done(0, cyc);
    check("c_done_cycles", cyc, 16);
    check("c_pass", pass_and, 1);
    check("c_err", err_and, 0);

    // y stuck at 0, hold 2: only vector 11 fails, mismatch coincides with done
    base = n_mm_h2;
    st_h2 = 1'b1;
    tick();
    st_h2 = 1'b0;
    wait_done(1, cyc);
    check("h2_done_cycles", cyc, 8);
    check("h2_mm_at_done", mm_h2, 1);
    check("h2_err", err_h2, 1);
    check("h2_ff", ff_h2, 3);
    check("h2_pass", pass_h2, 0);
    tick();
    check("h2_mm_pulses", n_mm_h2 - base, 1);

    // 400 failing samples saturate err_count
    base = n_mm_sat;
    st_sat = 1'b1;
    tick();
    st_sat = 1'b0;
    wait_done(2, cyc);
    check("sat_done_cycles", cyc, 400);
    check("sat_err", err_sat, 255);
    check("sat_ff", ff_sat, 0);
    check("sat_pass", pass_sat, 0);
    check("sat_mm_at_done", mm_sat, 1);
    tick();
    check("sat_mm_pulses", n_mm_sat - base, 400);

    // XOR checker fed an OR gate: differs only at 11
    st_xor = 1'b1;
    tick();
    st_xor = 1'b0;
    wait_done(3, cyc);
    check("xor_done_cycles", cyc, 12);
    check("xor_err", err_xor, 1);
    check("xor_ff", ff_xor, 3);
    check("xor_pass", pass_xor, 0);

    // NAND checker, correct gate, two passes
    base = n_mm_nand;
    st_nand = 1'b1;
    tick();
    st_nand = 1'b0;
    wait_done(4, cyc);
    check("nand_done_cycles", cyc, 8);
    check("nand_pass", pass_nand, 1);
    check("nand_err", err_nand, 0);
    tick();
    check("nand_mm_pulses", n_mm_nand - base, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
